// File: rtl/mem_wb_stage_if.sv
// Bundle of MEM->WB stage signals: MEM-side request/control, the synchronous
// dmem read data, and the register-file write port driven by the WB stage.
interface mem_wb_stage_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            i_stall;
  logic            i_flush;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_alu_result;
  logic [4:0]      i_rd_addr;
  logic            i_reg_write;
  logic            i_mem_read;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_dmem_rdata;
  logic            o_rd_wen;
  logic [4:0]      o_rd_addr;
  logic [XLEN-1:0] o_rd_wdata;
  logic            o_wb_valid;
  logic [XLEN-1:0] o_wb_pc;
  logic            o_load_misaligned;

  // Upstream pipeline / memory side: drives the stage, observes the write port
  modport master (
    output i_valid, i_stall, i_flush, i_pc, i_alu_result, i_rd_addr,
           i_reg_write, i_mem_read, i_funct3, i_dmem_rdata,
    input  o_rd_wen, o_rd_addr, o_rd_wdata, o_wb_valid, o_wb_pc,
           o_load_misaligned
  );

  // The WB stage itself
  modport slave (
    input  i_valid, i_stall, i_flush, i_pc, i_alu_result, i_rd_addr,
           i_reg_write, i_mem_read, i_funct3, i_dmem_rdata,
    output o_rd_wen, o_rd_addr, o_rd_wdata, o_wb_valid, o_wb_pc,
           o_load_misaligned
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers MEM-stage control and ALU result, takes the
// synchronous dmem read data one cycle later, formats loads (byte/half/word,
// sign/zero extension) and drives the register-file write port. A one-entry
// buffer keeps load data alive while the pipeline is stalled, because the
// memory only presents read data for a single cycle.
module mem_wb_stage #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  mem_wb_stage_if.slave bus
);

  logic            valid_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] alu_r;
  logic [4:0]      rd_r;
  logic            reg_write_r;
  logic            mem_read_r;
  logic [2:0]      funct3_r;
  logic [XLEN-1:0] buf_r;
  logic            buf_full_r;

  logic [XLEN-1:0] ld_raw_s;
  logic [7:0]      byte_s;
  logic [15:0]     half_s;
  logic [XLEN-1:0] fmt_s;
  logic            mis_size_s;
  logic            mis_s;

  // Pipeline control registers: capture when not stalled, hold otherwise (flush ignored while stalled)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      pc_r        <= RESET_PC_TAG;
      alu_r       <= '0;
      rd_r        <= 5'd0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      funct3_r    <= 3'b000;
    end else if (!bus.i_stall) begin
      valid_r     <= bus.i_valid & ~bus.i_flush;
      pc_r        <= bus.i_pc;
      alu_r       <= bus.i_alu_result;
      rd_r        <= bus.i_rd_addr;
      reg_write_r <= bus.i_reg_write;
      mem_read_r  <= bus.i_mem_read;
      funct3_r    <= bus.i_funct3;
    end
  end

  // Load-data capture buffer: grab the one-cycle read data on the first stall cycle of a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r      <= '0;
      buf_full_r <= 1'b0;
    end else if (!bus.i_stall) begin
      buf_full_r <= 1'b0;
    end else if (!buf_full_r && valid_r && mem_read_r) begin
      buf_r      <= bus.i_dmem_rdata;
      buf_full_r <= 1'b1;
    end
  end

  // Lane selection from the live read data or the buffered copy
  always_comb begin
    ld_raw_s = bus.i_dmem_rdata;
    byte_s   = 8'h00;
    half_s   = 16'h0000;
    if (buf_full_r) begin
      ld_raw_s = buf_r;
    end else begin
      ld_raw_s = bus.i_dmem_rdata;
    end
    case (alu_r[1:0])
      2'b00:   byte_s = ld_raw_s[7:0];
      2'b01:   byte_s = ld_raw_s[15:8];
      2'b10:   byte_s = ld_raw_s[23:16];
      2'b11:   byte_s = ld_raw_s[31:24];
      default: byte_s = 8'h00;
    endcase
    if (alu_r[1]) begin
      half_s = ld_raw_s[31:16];
    end else begin
      half_s = ld_raw_s[15:0];
    end
  end

  // Extension by load type plus size-vs-address misalignment detection
  always_comb begin
    fmt_s      = '0;
    mis_size_s = 1'b0;
    case (funct3_r)
      3'b000: fmt_s = {{24{byte_s[7]}}, byte_s};
      3'b001: begin
        fmt_s      = {{16{half_s[15]}}, half_s};
        mis_size_s = alu_r[0];
      end
      3'b010: begin
        fmt_s      = ld_raw_s;
        mis_size_s = |alu_r[1:0];
      end
      3'b100: fmt_s = {24'h00_0000, byte_s};
      3'b101: begin
        fmt_s      = {16'h0000, half_s};
        mis_size_s = alu_r[0];
      end
      default: begin
        fmt_s      = '0;
        mis_size_s = 1'b0;
      end
    endcase
  end

  // Register-file write port; misaligned loads and writes to x0 are suppressed
  always_comb begin
    mis_s = valid_r & mem_read_r & mis_size_s;
    if (mem_read_r) begin
      bus.o_rd_wdata = fmt_s;
    end else begin
      bus.o_rd_wdata = alu_r;
    end
    bus.o_rd_wen          = valid_r & reg_write_r & (rd_r != 5'd0) & ~mis_s;
    bus.o_rd_addr         = rd_r;
    bus.o_wb_valid        = valid_r;
    bus.o_wb_pc           = pc_r;
    bus.o_load_misaligned = mis_s;
  end

endmodule
